// File: rtl/eth_parser_pkg.sv
// Shared types, TPID constants and helpers for the streaming Ethernet II header parser.
package eth_parser_pkg;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] ethertype_t;
  typedef logic [15:0] vlan_tci_t;

  localparam ethertype_t TPID_8021Q  = 16'h8100;
  localparam ethertype_t TPID_8021AD = 16'h88A8;
  localparam ethertype_t TPID_9100   = 16'h9100;

  localparam int ETH_BASE_HDR_BYTES = 14;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DRAIN   = 2'd2
  } parser_state_e;

  function automatic logic is_tpid(input ethertype_t et);
    case (et)
      TPID_8021Q, TPID_8021AD, TPID_9100: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/eth_hdr_field_extract.sv
// Combinational decode of the captured header buffer: tag walk, required length and field values.
module eth_hdr_field_extract
  import eth_parser_pkg::*;
#(
  parameter int MAX_VLAN_TAGS = 2
) (
  input  logic [8*(ETH_BASE_HDR_BYTES+4*MAX_VLAN_TAGS)-1:0] hdr_buf,
  input  logic [5:0]                                         byte_cnt,
  output logic [5:0]                                         req_len,
  output logic [1:0]                                         vlan_count,
  output mac_addr_t                                          dest_mac,
  output mac_addr_t                                          src_mac,
  output ethertype_t                                         ethertype,
  output vlan_tci_t [MAX_VLAN_TAGS-1:0]                      vlan_tci
);

  logic       chain_s;
  logic [1:0] n_tpid_s;
  logic [1:0] n_full_s;
  ethertype_t tpid_s;

  // Walk the tag stack; a TPID only counts once both of its bytes have actually arrived
  always_comb begin
    dest_mac  = 48'd0;
    src_mac   = 48'd0;
    ethertype = 16'd0;
    vlan_tci  = '0;
    chain_s   = 1'b1;
    n_tpid_s  = 2'd0;
    n_full_s  = 2'd0;
    tpid_s    = 16'd0;
    for (int i = 0; i < 6; i++) begin
      dest_mac[8*(5-i) +: 8] = hdr_buf[8*i +: 8];
      src_mac[8*(5-i) +: 8]  = hdr_buf[8*(6+i) +: 8];
    end
    for (int k = 0; k < MAX_VLAN_TAGS; k++) begin
      tpid_s = {hdr_buf[8*(12+4*k) +: 8], hdr_buf[8*(13+4*k) +: 8]};
      if (chain_s && (byte_cnt >= 6'(14+4*k)) && is_tpid(tpid_s)) begin
        n_tpid_s = n_tpid_s + 2'd1;
        n_full_s = (byte_cnt >= 6'(16+4*k)) ? (n_full_s + 2'd1) : n_full_s;
      end else begin
        chain_s = 1'b0;
      end
    end
    for (int k = 0; k <= MAX_VLAN_TAGS; k++) begin
      ethertype = (n_tpid_s == 2'(k)) ?
                  {hdr_buf[8*(12+4*k) +: 8], hdr_buf[8*(13+4*k) +: 8]} : ethertype;
    end
    for (int k = 0; k < MAX_VLAN_TAGS; k++) begin
      vlan_tci[k] = (n_full_s > 2'(k)) ?
                    {hdr_buf[8*(14+4*k) +: 8], hdr_buf[8*(15+4*k) +: 8]} : 16'd0;
    end
    req_len    = 6'd14 + {2'd0, n_tpid_s, 2'b00};
    vlan_count = n_full_s;
  end

endmodule

// File: rtl/eth_stream_header_parser.sv
// Streaming Ethernet II header parser with stacked VLAN tag walk and held header output.
// Optional statistics counters are enabled by defining ETH_PARSER_STATS_EN.
module eth_stream_header_parser
  import eth_parser_pkg::*;
#(
  parameter int DATA_BYTES    = 4,
  parameter int MAX_VLAN_TAGS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*DATA_BYTES-1:0]       s_data,
  input  logic [DATA_BYTES-1:0]         s_keep,
  input  logic                          s_valid,
  input  logic                          s_last,
  output logic                          s_ready,
  output mac_addr_t                     dest_mac,
  output mac_addr_t                     src_mac,
  output ethertype_t                    ethertype,
  output logic [1:0]                    vlan_count,
  output vlan_tci_t [MAX_VLAN_TAGS-1:0] vlan_tci,
  output logic                          hdr_err,
  output logic                          hdr_valid,
`ifdef ETH_PARSER_STATS_EN
  output logic [31:0]                   stat_frames,
  output logic [31:0]                   stat_runts,
  output logic [31:0]                   stat_tagged,
`endif
  input  logic                          hdr_ready
);

  localparam int HDR_MAX_BYTES = ETH_BASE_HDR_BYTES + 4*MAX_VLAN_TAGS;

  parser_state_e                 state_q, state_d;
  logic [5:0]                    byte_cnt_q, byte_cnt_d;
  logic [8*HDR_MAX_BYTES-1:0]    hdr_buf_q, hdr_buf_d;
  logic                          last_seen_q, last_seen_d;
  mac_addr_t                     dest_mac_q, dest_mac_d;
  mac_addr_t                     src_mac_q, src_mac_d;
  ethertype_t                    ethertype_q, ethertype_d;
  logic [1:0]                    vlan_count_q, vlan_count_d;
  vlan_tci_t [MAX_VLAN_TAGS-1:0] vlan_tci_q, vlan_tci_d;
  logic                          hdr_valid_q, hdr_valid_d;
  logic                          hdr_err_q, hdr_err_d;

  logic                          beat_acc_s;
  logic                          hdr_hs_s;
  logic [8*HDR_MAX_BYTES-1:0]    beat_buf_s;
  logic [5:0]                    beat_cnt_s;
  logic [3:0]                    keep_cnt_s;
  logic [6:0]                    cnt_sum_s;

  logic [5:0]                    ex_req_len_s;
  logic [1:0]                    ex_vlan_count_s;
  mac_addr_t                     ex_dest_s;
  mac_addr_t                     ex_src_s;
  ethertype_t                    ex_etype_s;
  vlan_tci_t [MAX_VLAN_TAGS-1:0] ex_tci_s;

  assign s_ready    = ((state_q == ST_COLLECT) || (state_q == ST_DRAIN)) && !rst;
  assign beat_acc_s = s_valid && s_ready;
  assign hdr_hs_s   = hdr_valid_q && hdr_ready;

  // Buffer and byte count as they would look after merging the current beat
  always_comb begin
    beat_buf_s = hdr_buf_q;
    keep_cnt_s = 4'd0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      keep_cnt_s = keep_cnt_s + {3'd0, s_keep[i]};
    end
    for (int j = 0; j < HDR_MAX_BYTES; j++) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        beat_buf_s[8*j +: 8] = (s_keep[i] && (({1'b0, byte_cnt_q} + 7'(i)) == 7'(j))) ?
                               s_data[8*i +: 8] : beat_buf_s[8*j +: 8];
      end
    end
    cnt_sum_s = {1'b0, byte_cnt_q} + {3'd0, keep_cnt_s};
    if (cnt_sum_s > 7'(HDR_MAX_BYTES)) begin
      beat_cnt_s = 6'(HDR_MAX_BYTES);
    end else begin
      beat_cnt_s = cnt_sum_s[5:0];
    end
  end

  eth_hdr_field_extract #(
    .MAX_VLAN_TAGS (MAX_VLAN_TAGS)
  ) u_extract (
    .hdr_buf    (beat_buf_s),
    .byte_cnt   (beat_cnt_s),
    .req_len    (ex_req_len_s),
    .vlan_count (ex_vlan_count_s),
    .dest_mac   (ex_dest_s),
    .src_mac    (ex_src_s),
    .ethertype  (ex_etype_s),
    .vlan_tci   (ex_tci_s)
  );

  // Next-state and field capture
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    hdr_buf_d    = hdr_buf_q;
    last_seen_d  = last_seen_q;
    dest_mac_d   = dest_mac_q;
    src_mac_d    = src_mac_q;
    ethertype_d  = ethertype_q;
    vlan_count_d = vlan_count_q;
    vlan_tci_d   = vlan_tci_q;
    hdr_valid_d  = hdr_valid_q;
    hdr_err_d    = hdr_err_q;
    case (state_q)
      ST_COLLECT: begin
        if (beat_acc_s) begin
          hdr_buf_d  = beat_buf_s;
          byte_cnt_d = beat_cnt_s;
          // A runt is an s_last beat that still leaves the header short
          if ((beat_cnt_s >= ex_req_len_s) || s_last) begin
            dest_mac_d   = ex_dest_s;
            src_mac_d    = ex_src_s;
            ethertype_d  = ex_etype_s;
            vlan_count_d = ex_vlan_count_s;
            vlan_tci_d   = ex_tci_s;
            hdr_valid_d  = 1'b1;
            hdr_err_d    = (beat_cnt_s < ex_req_len_s);
            last_seen_d  = s_last;
            state_d      = ST_HOLD;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_HOLD: begin
        if (hdr_ready) begin
          hdr_valid_d = 1'b0;
          hdr_err_d   = 1'b0;
          byte_cnt_d  = 6'd0;
          hdr_buf_d   = '0;
          last_seen_d = 1'b0;
          state_d     = last_seen_q ? ST_COLLECT : ST_DRAIN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (beat_acc_s && s_last) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d     = ST_COLLECT;
        byte_cnt_d  = 6'd0;
        hdr_buf_d   = '0;
        hdr_valid_d = 1'b0;
        hdr_err_d   = 1'b0;
      end
    endcase
  end

  // State and registered header fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      byte_cnt_q   <= 6'd0;
      hdr_buf_q    <= '0;
      last_seen_q  <= 1'b0;
      dest_mac_q   <= 48'd0;
      src_mac_q    <= 48'd0;
      ethertype_q  <= 16'd0;
      vlan_count_q <= 2'd0;
      vlan_tci_q   <= '0;
      hdr_valid_q  <= 1'b0;
      hdr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      hdr_buf_q    <= hdr_buf_d;
      last_seen_q  <= last_seen_d;
      dest_mac_q   <= dest_mac_d;
      src_mac_q    <= src_mac_d;
      ethertype_q  <= ethertype_d;
      vlan_count_q <= vlan_count_d;
      vlan_tci_q   <= vlan_tci_d;
      hdr_valid_q  <= hdr_valid_d;
      hdr_err_q    <= hdr_err_d;
    end
  end

  assign dest_mac   = dest_mac_q;
  assign src_mac    = src_mac_q;
  assign ethertype  = ethertype_q;
  assign vlan_count = vlan_count_q;
  assign vlan_tci   = vlan_tci_q;
  assign hdr_valid  = hdr_valid_q;
  assign hdr_err    = hdr_err_q;

`ifdef ETH_PARSER_STATS_EN
  logic [31:0] stat_frames_q, stat_frames_d;
  logic [31:0] stat_runts_q, stat_runts_d;
  logic [31:0] stat_tagged_q, stat_tagged_d;

  // Counters advance on the header handshake only
  always_comb begin
    stat_frames_d = stat_frames_q;
    stat_runts_d  = stat_runts_q;
    stat_tagged_d = stat_tagged_q;
    if (hdr_hs_s) begin
      stat_frames_d = stat_frames_q + 32'd1;
      stat_runts_d  = hdr_err_q ? (stat_runts_q + 32'd1) : stat_runts_q;
      stat_tagged_d = (vlan_count_q != 2'd0) ? (stat_tagged_q + 32'd1) : stat_tagged_q;
    end else begin
      stat_frames_d = stat_frames_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames_q <= 32'd0;
      stat_runts_q  <= 32'd0;
      stat_tagged_q <= 32'd0;
    end else begin
      stat_frames_q <= stat_frames_d;
      stat_runts_q  <= stat_runts_d;
      stat_tagged_q <= stat_tagged_d;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_runts  = stat_runts_q;
  assign stat_tagged = stat_tagged_q;
`endif

endmodule

// File: tb/tb_eth_stream_header_parser.sv
// Scoreboard bench for eth_stream_header_parser: directed frames, monitor-side header checks.
module tb_eth_stream_header_parser;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      s_data;
  logic [3:0]       s_keep;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [47:0]      dest_mac;
  logic [47:0]      src_mac;
  logic [15:0]      ethertype;
  logic [1:0]       vlan_count;
  logic [1:0][15:0] vlan_tci;
  logic             hdr_err;
  logic             hdr_valid;
  logic             hdr_ready;
`ifdef ETH_PARSER_STATS_EN
  logic [31:0]      stat_frames;
  logic [31:0]      stat_runts;
  logic [31:0]      stat_tagged;
`endif

  eth_stream_header_parser #(
    .DATA_BYTES    (4),
    .MAX_VLAN_TAGS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_keep     (s_keep),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .dest_mac   (dest_mac),
    .src_mac    (src_mac),
    .ethertype  (ethertype),
    .vlan_count (vlan_count),
    .vlan_tci   (vlan_tci),
    .hdr_err    (hdr_err),
    .hdr_valid  (hdr_valid),
`ifdef ETH_PARSER_STATS_EN
    .stat_frames (stat_frames),
    .stat_runts  (stat_runts),
    .stat_tagged (stat_tagged),
`endif
    .hdr_ready  (hdr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] d;
    logic [47:0] s;
    logic [15:0] et;
    logic [1:0]  vc;
    logic [15:0] t0;
    logic [15:0] t1;
    logic        err;
  } exp_t;

  exp_t       exp_q[$];
  time        lat_q[$];
  logic [7:0] fr [0:127];
  int         checks    = 0;
  int         errors    = 0;
  int         hdrs_seen = 0;
  int         bp_req    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build(input logic [47:0] d, input logic [47:0] s);
    for (int i = 0; i < 128; i++) fr[i] = 8'(i*7 + 3);
    for (int i = 0; i < 6; i++) begin
      fr[i]   = d[47-8*i -: 8];
      fr[6+i] = s[47-8*i -: 8];
    end
  endtask

  task automatic put16(input int off, input logic [15:0] v);
    fr[off]   = v[15:8];
    fr[off+1] = v[7:0];
  endtask

  task automatic expect_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                            input logic [1:0] vc, input logic [15:0] t0, input logic [15:0] t1,
                            input logic err);
    exp_t e;
    e.d = d; e.s = s; e.et = et; e.vc = vc; e.t0 = t0; e.t1 = t1; e.err = err;
    exp_q.push_back(e);
  endtask

  // Drive one beat and hold it until accepted (bounded wait)
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           output time t_acc, output bit ok);
    bit acc;
    int waited;
    acc = 1'b0; waited = 0; ok = 1'b1; t_acc = 0;
    s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      t_acc = $time;
      #1;
      waited++;
      if (!acc && waited > 200) begin
        checks++; errors++;
        $display("FAIL beat_timeout: got no s_ready after %0d cycles required acceptance", waited);
        ok = 1'b0;
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input int comp_beat, input bit bubbles, input int stop_after);
    logic [31:0] d;
    logic [3:0]  k;
    time         t;
    bit          ok;
    for (int b = 0; b < (len + 3) / 4; b++) begin
      if (stop_after >= 0 && b > stop_after) break;
      d = 32'd0; k = 4'd0;
      for (int i = 0; i < 4; i++) begin
        if (4*b + i < len) begin
          d[8*i +: 8] = fr[4*b + i];
          k[i] = 1'b1;
        end
      end
      send_beat(d, k, (4*b + 4 >= len), t, ok);
      if (!ok) return;
      if (b == comp_beat) lat_q.push_back(t);
      if (bubbles && (b % 2 == 1)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Downstream ready: optionally stall a header for bp_req cycles
  initial begin
    hdr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hdr_valid && bp_req > 0) begin
        hdr_ready = 1'b0;
        bp_req--;
      end else begin
        hdr_ready = 1'b1;
      end
    end
  end

  // Monitor: latency, hold stability, s_ready gating and header comparison
  initial begin
    logic [146:0] snap;
    logic [146:0] cur;
    logic         prev_v;
    logic         prev_r;
    time          t;
    exp_t         e;
    prev_v = 1'b0; prev_r = 1'b0; snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0; prev_r = 1'b0;
      end else begin
        cur = {dest_mac, src_mac, ethertype, vlan_count, vlan_tci, hdr_err};
        if (hdr_valid) begin
          chk("s_ready_in_hold", 64'(s_ready), 64'd0);
          if (!prev_v) begin
            if (lat_q.size() == 0) begin
              chk("unexpected_valid_rise", 64'd1, 64'd0);
            end else begin
              t = lat_q.pop_front();
              chk("hdr_latency_time", 64'($time), 64'(t + 5));
            end
          end else if (!prev_r) begin
            checks++;
            if (cur !== snap) begin
              errors++;
              $display("FAIL hold_stable: got %h required %h", cur, snap);
            end
          end
          snap = cur;
          if (hdr_ready) begin
            hdrs_seen++;
            if (exp_q.size() == 0) begin
              chk("unexpected_hdr", 64'd1, 64'd0);
            end else begin
              e = exp_q.pop_front();
              chk("dest_mac",   64'(dest_mac),    64'(e.d));
              chk("src_mac",    64'(src_mac),     64'(e.s));
              chk("ethertype",  64'(ethertype),   64'(e.et));
              chk("vlan_count", 64'(vlan_count),  64'(e.vc));
              chk("vlan_tci0",  64'(vlan_tci[0]), 64'(e.t0));
              chk("vlan_tci1",  64'(vlan_tci[1]), 64'(e.t1));
              chk("hdr_err",    64'(hdr_err),     64'(e.err));
            end
          end
        end else begin
          chk("s_ready_outside_hold", 64'(s_ready), 64'd1);
        end
        prev_v = hdr_valid;
        prev_r = hdr_ready;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 32'd0; s_keep = 4'd0; s_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready",    64'(s_ready),    64'd0);
    chk("rst_hdr_valid",  64'(hdr_valid),  64'd0);
    chk("rst_hdr_err",    64'(hdr_err),    64'd0);
    chk("rst_dest_mac",   64'(dest_mac),   64'd0);
    chk("rst_src_mac",    64'(src_mac),    64'd0);
    chk("rst_ethertype",  64'(ethertype),  64'd0);
    chk("rst_vlan_count", 64'(vlan_count), 64'd0);
    chk("rst_vlan_tci",   64'(vlan_tci),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Untagged 64-byte frame
    build(48'h001122334455, 48'h66778899AABB); put16(12, 16'h0800);
    expect_hdr(48'h001122334455, 48'h66778899AABB, 16'h0800, 2'd0, 16'h0000, 16'h0000, 1'b0);
    send_frame(64, 3, 1'b0, -1);

    // Single 802.1Q tag, with input bubbles
    build(48'h02AABBCCDDEE, 48'h0A0B0C0D0E0F);
    put16(12, 16'h8100); put16(14, 16'h6064); put16(16, 16'h86DD);
    expect_hdr(48'h02AABBCCDDEE, 48'h0A0B0C0D0E0F, 16'h86DD, 2'd1, 16'h6064, 16'h0000, 1'b0);
    send_frame(64, 4, 1'b1, -1);

    // QinQ
    build(48'h0E0D0C0B0A09, 48'h123456789ABC);
    put16(12, 16'h88A8); put16(14, 16'h0ABC); put16(16, 16'h8100); put16(18, 16'h2123);
    put16(20, 16'h0800);
    expect_hdr(48'h0E0D0C0B0A09, 48'h123456789ABC, 16'h0800, 2'd2, 16'h0ABC, 16'h2123, 1'b0);
    send_frame(68, 5, 1'b0, -1);

    // 10-byte runt
    build(48'h001122334455, 48'h66778899AABB);
    expect_hdr(48'h001122334455, 48'h667788990000, 16'h0000, 2'd0, 16'h0000, 16'h0000, 1'b1);
    send_frame(10, 2, 1'b0, -1);

    // Exactly 14 bytes, header completes on the last beat
    build(48'h010203040506, 48'h0708090A0B0C); put16(12, 16'h88B5);
    expect_hdr(48'h010203040506, 48'h0708090A0B0C, 16'h88B5, 2'd0, 16'h0000, 16'h0000, 1'b0);
    send_frame(14, 3, 1'b0, -1);

    // 16-byte runt ending after one full tag
    build(48'h111111111111, 48'h222222222222); put16(12, 16'h9100); put16(14, 16'h0FFF);
    expect_hdr(48'h111111111111, 48'h222222222222, 16'h0000, 2'd1, 16'h0FFF, 16'h0000, 1'b1);
    send_frame(16, 3, 1'b0, -1);

    // Header stalled 20 cycles by downstream
    bp_req = 20;
    build(48'hAABBCCDDEEFF, 48'h112233445566); put16(12, 16'h0806);
    expect_hdr(48'hAABBCCDDEEFF, 48'h112233445566, 16'h0806, 2'd0, 16'h0000, 16'h0000, 1'b0);
    send_frame(60, 3, 1'b0, -1);

    // Third TPID beyond the cap is reported as the ethertype
    build(48'h334455667788, 48'h99AABBCCDDEE);
    put16(12, 16'h8100); put16(14, 16'h0001); put16(16, 16'h88A8); put16(18, 16'h0002);
    put16(20, 16'h9100);
    expect_hdr(48'h334455667788, 48'h99AABBCCDDEE, 16'h9100, 2'd2, 16'h0001, 16'h0002, 1'b0);
    send_frame(64, 5, 1'b0, -1);

    // Frame A: reset while draining
    build(48'hDEADBEEF0001, 48'hCAFEF00D0002); put16(12, 16'h0800);
    expect_hdr(48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h0800, 2'd0, 16'h0000, 16'h0000, 1'b0);
    send_frame(64, 3, 1'b0, 7);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Frame B after reset
    build(48'h00A0C9000001, 48'h00A0C9000002);
    put16(12, 16'h8100); put16(14, 16'h0123); put16(16, 16'h0800);
    expect_hdr(48'h00A0C9000001, 48'h00A0C9000002, 16'h0800, 2'd1, 16'h0123, 16'h0000, 1'b0);
    send_frame(40, 4, 1'b0, -1);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (3) @(negedge clk);
    chk("pending_hdrs", 64'(exp_q.size()), 64'd0);
    chk("pending_lat",  64'(lat_q.size()), 64'd0);
    chk("hdr_count",    64'(hdrs_seen),    64'd10);
`ifdef ETH_PARSER_STATS_EN
    chk("stat_frames", 64'(stat_frames), 64'd1);
    chk("stat_runts",  64'(stat_runts),  64'd0);
    chk("stat_tagged", 64'(stat_tagged), 64'd1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_stream_header_parser.md
Name: eth_stream_header_parser

Overview:
- Streaming successor to the flat-array Ethernet II decoder.
- Accepts a frame as a valid/ready byte stream DATA_BYTES wide and accumulates header bytes across beats.
- Walks up to MAX_VLAN_TAGS stacked 802.1Q/802.1ad tags, then presents the decoded header once per frame on a held valid/ready output.
- Consumes and discards the rest of the frame. Sits between MAC RX stream and the classification stage.

Parameters:
DATA_BYTES, 4, bytes per input beat; legal 1, 2, 4, 8
MAX_VLAN_TAGS, 2, max tags decoded; legal 1..2
HDR_MAX_BYTES, 14+4*MAX_VLAN_TAGS, derived localparam, capture buffer size

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_data  in  8*DATA_BYTES  frame bytes; lane i = s_data[8i+7:8i]; lane 0 is earliest byte
s_keep  in  DATA_BYTES  valid lanes, contiguous from lane 0; all-ones except on last beat
s_valid  in  1  beat valid
s_last  in  1  final beat of frame
s_ready  out  1  beat accepted when s_valid && s_ready
dest_mac  out  48  destination MAC (mac_addr_t)
src_mac  out  48  source MAC (mac_addr_t)
ethertype  out  16  first non-TPID ethertype (ethertype_t)
vlan_count  out  2  tags decoded, 0..MAX_VLAN_TAGS
vlan_tci  out  MAX_VLAN_TAGS x 16  TCI per tag, index 0 = outer; unused entries 0
hdr_err  out  1  runt: frame ended before required header length
hdr_valid  out  1  header fields valid
hdr_ready  in  1  downstream accepts header

Behaviour:
- Reset: state COLLECT, byte_cnt=0, buffer cleared. All field outputs, hdr_valid and hdr_err are 0. s_ready is 0 while rst is high.
- States: COLLECT, HOLD, DRAIN. s_ready = (state==COLLECT || state==DRAIN) && !rst.
- COLLECT, on each accepted beat:
  - Each kept lane i writes buffer[byte_cnt+i] if that index < HDR_MAX_BYTES.
  - byte_cnt advances by popcount(s_keep), saturating at HDR_MAX_BYTES; byte_cnt is 6 bits.
- Required length req_len = 14 + 4*n:
  - n = number of consecutive TPIDs (0x8100, 0x88A8, 0x9100) at offsets 12, 16, ..., capped at MAX_VLAN_TAGS.
  - req_len is evaluated on the post-beat byte count, so one beat can both reveal a TPID and complete the extended header.
  - If a TPID appears beyond the cap, ethertype reports that TPID; this is not an error.
- Header complete (byte_cnt >= req_len after the beat):
  - Register fields; hdr_valid=1, hdr_err=0 on the next cycle (latency 1 cycle after the completing beat).
  - Go to HOLD. Record whether the completing beat carried s_last.
- Runt (s_last accepted before completion):
  - Register captured fields; missing bytes read 0.
  - vlan_count = tags fully captured; hdr_err=1, hdr_valid=1; go to HOLD.
- HOLD:
  - Outputs stable and s_ready=0 until hdr_valid && hdr_ready.
  - On that handshake: if the frame already ended, go to COLLECT with byte_cnt=0 and buffer cleared; otherwise go to DRAIN.
  - hdr_valid and hdr_err clear on the handshake; fields hold their last value.
- DRAIN: accept and discard beats; on accepted s_last go to COLLECT with byte_cnt=0.
- Header bytes are big-endian: dest_mac = {b0..b5}, src_mac = {b6..b11}, TCI k = {b(14+4k), b(15+4k)}.
- s_valid low inserts bubbles freely in any state; no state changes without an accepted beat or handshake.
- Asynchronous reset mid-frame or mid-HOLD discards everything; the next accepted beat is treated as byte 0.

Optional Feature:
- Macro: ETH_PARSER_STATS_EN.
- When defined:
  - Adds 32-bit wrapping outputs stat_frames, stat_runts, stat_tagged (vlan_count>0), reset to 0.
  - Each increments by 1 on the header handshake matching its condition.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- eth_parser_pkg gains:
  - TPID_8021Q, TPID_8021AD and TPID_9100 constants;
  - vlan_tci_t (16 bits);
  - parser_state_e enum;
  - function is_tpid(ethertype_t).
- Reuse existing mac_addr_t and ethertype_t.
- One combinational sub-module, eth_hdr_field_extract: takes buffer plus byte_cnt and produces req_len, vlan_count, and all field values; the FSM registers these.

Test Plan:
- DATA_BYTES=4, untagged 64-byte frame, dest 00:11:22:33:44:55, src 66:77:88:99:AA:BB, type 0x0800 -> hdr_valid one cycle after beat 3; exact fields; vlan_count=0; remaining 12 beats drained; s_ready low only during HOLD.
- Single tag 0x8100, TCI 0x6064, inner 0x86DD -> vlan_count=1, vlan_tci[0]=0x6064, ethertype=0x86DD, valid after beat 4.
- QinQ 0x88A8/TCI 0x0ABC then 0x8100/TCI 0x2123, inner 0x0800 -> vlan_count=2, TCIs in order, ethertype=0x0800.
- Runt: 10-byte frame (3 beats, s_keep=0x3 on last) -> hdr_valid with hdr_err=1, src_mac low bytes 0, no DRAIN, next frame parsed cleanly.
- Backpressure: hold hdr_ready=0 for 20 cycles with s_valid=1 -> s_ready=0, outputs stable throughout; back-to-back frames each yield exactly one header.
- Assert rst during DRAIN of frame A, then send frame B -> B's fields correct; with ETH_PARSER_STATS_EN, stat_frames counts only B.
